// File: rtl/cu_pkg.sv
// Shared encodings for control_unit_v2: FSM states, opcodes and datapath
// select values.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_NOOP,
    ST_STORE,
    ST_LOAD,
    ST_ADD,
    ST_SUB,
    ST_LDI,
    ST_JPZ,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_LDI   = 4'd5,
    OP_JPZ   = 4'd6,
    OP_HALT  = 4'd7
  } opcode_e;

  localparam logic [1:0] RF_S_ALU = 2'd0;
  localparam logic [1:0] RF_S_MEM = 2'd1;
  localparam logic [1:0] RF_S_IMM = 2'd2;

  localparam int unsigned ALU_PASS = 0;
  localparam int unsigned ALU_ADD  = 1;
  localparam int unsigned ALU_SUB  = 2;

endpackage

// File: rtl/control_unit_v2.sv
// Multi-cycle control FSM: fetch/decode/execute sequencing for the simple
// 16-bit ISA, with a fixed-latency LOAD and a HALT/resume handshake.
module control_unit_v2
  import cu_pkg::*;
#(
  parameter int D_ADDR_W  = 8,
  parameter int RF_ADDR_W = 4,
  parameter int ALU_SEL_W = 3,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          instr,
  input  logic                 ra_zero,
  input  logic                 resume,
  output logic                 pc_clr,
  output logic                 pc_up,
  output logic                 pc_ld,
  output logic [7:0]           pc_offset,
  output logic                 ir_ld,
  output logic [D_ADDR_W-1:0]  d_addr,
  output logic                 d_wr,
  output logic [1:0]           rf_s,
  output logic [7:0]           rf_imm,
  output logic [RF_ADDR_W-1:0] rf_w_addr,
  output logic [RF_ADDR_W-1:0] rf_ra_addr,
  output logic [RF_ADDR_W-1:0] rf_rb_addr,
  output logic                 rf_w_en,
  output logic [ALU_SEL_W-1:0] alu_s,
  output logic [3:0]           state_out,
  output logic                 halted,
  output logic                 illegal
);

  state_e     state, state_nx;
  logic [2:0] lat_cnt;
  logic       last_beat;
  logic [7:0] store_addr, load_addr;

  assign store_addr = instr[7:0];
  assign load_addr  = instr[11:4];
  assign last_beat  = (lat_cnt == 3'(MEM_LAT - 1));
  assign state_out  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_INIT;
      lat_cnt <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nx;
      // Counter idles at zero outside LOAD, so it is cleared on every entry.
      lat_cnt <= (state == ST_LOAD) ? lat_cnt + 3'd1 : '0;
      if (state == ST_DECODE && instr[15])
        illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    pc_ld      = 1'b0;
    pc_offset  = '0;
    ir_ld      = 1'b0;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = RF_S_ALU;
    rf_imm     = '0;
    rf_w_addr  = '0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    rf_w_en    = 1'b0;
    alu_s      = ALU_SEL_W'(ALU_PASS);
    halted     = 1'b0;

    case (state)
      ST_INIT: begin
        pc_clr   = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        pc_up    = 1'b1;
        ir_ld    = 1'b1;
        state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        case (instr[15:12])
          OP_NOOP:  state_nx = ST_NOOP;
          OP_STORE: state_nx = ST_STORE;
          OP_LOAD:  state_nx = ST_LOAD;
          OP_ADD:   state_nx = ST_ADD;
          OP_SUB:   state_nx = ST_SUB;
          OP_LDI:   state_nx = ST_LDI;
          OP_JPZ:   state_nx = ST_JPZ;
          default:  state_nx = ST_HALT;
        endcase
      end
      ST_NOOP: state_nx = ST_FETCH;
      ST_STORE: begin
        d_addr     = D_ADDR_W'(store_addr);
        rf_ra_addr = RF_ADDR_W'(instr[11:8]);
        d_wr       = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_LOAD: begin
        d_addr    = D_ADDR_W'(load_addr);
        rf_s      = RF_S_MEM;
        rf_w_addr = RF_ADDR_W'(instr[3:0]);
        rf_w_en   = last_beat;
        if (last_beat)
          state_nx = ST_FETCH;
      end
      ST_ADD, ST_SUB: begin
        rf_ra_addr = RF_ADDR_W'(instr[11:8]);
        rf_rb_addr = RF_ADDR_W'(instr[7:4]);
        rf_w_addr  = RF_ADDR_W'(instr[3:0]);
        rf_w_en    = 1'b1;
        alu_s      = (state == ST_ADD) ? ALU_SEL_W'(ALU_ADD) : ALU_SEL_W'(ALU_SUB);
        state_nx   = ST_FETCH;
      end
      ST_LDI: begin
        rf_s      = RF_S_IMM;
        rf_imm    = instr[11:4];
        rf_w_addr = RF_ADDR_W'(instr[3:0]);
        rf_w_en   = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_JPZ: begin
        rf_ra_addr = RF_ADDR_W'(instr[11:8]);
        if (ra_zero) begin
          pc_ld     = 1'b1;
          pc_offset = instr[7:0];
        end
        state_nx = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume)
          state_nx = ST_FETCH;
      end
      default: state_nx = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_control_unit_v2.sv
// Randomized instruction-level bench for control_unit_v2 against a per-instruction
// cycle-sequence reference model.
module tb_control_unit_v2;
  import cu_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        ra_zero, resume;
  logic        pc_clr, pc_up, pc_ld, ir_ld, d_wr, rf_w_en, halted, illegal;
  logic [7:0]  pc_offset, d_addr, rf_imm;
  logic [1:0]  rf_s;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_out;
  logic [2:0]  alu_s;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        ill_m;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_clr, pc_up, pc_ld;
    logic [7:0] pc_offset;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic [1:0] rf_s;
    logic [7:0] rf_imm;
    logic [3:0] w_addr, ra, rb;
    logic       w_en;
    logic [2:0] alu_s;
    logic       halted;
  } exp_t;

  always #5 clk = ~clk;

  control_unit_v2 #(
    .D_ADDR_W (8),
    .RF_ADDR_W(4),
    .ALU_SEL_W(3),
    .MEM_LAT  (LAT)
  ) dut (
    .clk(clk), .reset(reset), .instr(instr), .ra_zero(ra_zero), .resume(resume),
    .pc_clr(pc_clr), .pc_up(pc_up), .pc_ld(pc_ld), .pc_offset(pc_offset),
    .ir_ld(ir_ld), .d_addr(d_addr), .d_wr(d_wr), .rf_s(rf_s), .rf_imm(rf_imm),
    .rf_w_addr(rf_w_addr), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_w_en(rf_w_en), .alu_s(alu_s), .state_out(state_out), .halted(halted),
    .illegal(illegal)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s instr=%h t=%0t: got=%0h expected=%0h", tag, instr, $time, got, exp);
    end
  endtask

  function automatic exp_t idle(input state_e s);
    exp_t e;
    e    = '0;
    e.st = s;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check_val("state",     state_out,  e.st);
    check_val("pc_clr",    pc_clr,     e.pc_clr);
    check_val("pc_up",     pc_up,      e.pc_up);
    check_val("pc_ld",     pc_ld,      e.pc_ld);
    check_val("pc_offset", pc_offset,  e.pc_offset);
    check_val("ir_ld",     ir_ld,      e.ir_ld);
    check_val("d_addr",    d_addr,     e.d_addr);
    check_val("d_wr",      d_wr,       e.d_wr);
    check_val("rf_s",      rf_s,       e.rf_s);
    check_val("rf_imm",    rf_imm,     e.rf_imm);
    check_val("rf_w_addr", rf_w_addr,  e.w_addr);
    check_val("rf_ra",     rf_ra_addr, e.ra);
    check_val("rf_rb",     rf_rb_addr, e.rb);
    check_val("rf_w_en",   rf_w_en,    e.w_en);
    check_val("alu_s",     alu_s,      e.alu_s);
    check_val("halted",    halted,     e.halted);
    check_val("illegal",   illegal,    ill_m);
  endtask

  // Check the current cycle, then advance to just after the next rising edge.
  task automatic step(input exp_t e, input logic rs);
    resume = rs;
    #1;
    compare(e);
    @(posedge clk);
    #1;
  endtask

  // Leading cycles of every instruction: FETCH then DECODE; illegal latches on the DECODE edge.
  task automatic fetch_decode(input logic [15:0] ins);
    exp_t e;
    e       = idle(ST_FETCH);
    e.pc_up = 1'b1;
    e.ir_ld = 1'b1;
    step(e, 1'($urandom_range(0, 1)));
    step(idle(ST_DECODE), 1'($urandom_range(0, 1)));
    if (ins[15:12] >= 4'd8) ill_m = 1'b1;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic rz);
    exp_t e;
    int unsigned n;
    instr   = ins;
    ra_zero = rz;
    fetch_decode(ins);
    case (ins[15:12])
      4'd0: step(idle(ST_NOOP), 1'($urandom_range(0, 1)));
      4'd1: begin
        e = idle(ST_STORE); e.d_addr = ins[7:0]; e.ra = ins[11:8]; e.d_wr = 1'b1;
        step(e, 1'($urandom_range(0, 1)));
      end
      4'd2: for (int k = 0; k < LAT; k++) begin
        e = idle(ST_LOAD); e.d_addr = ins[11:4]; e.rf_s = 2'd1; e.w_addr = ins[3:0];
        e.w_en = (k == LAT - 1);
        step(e, 1'($urandom_range(0, 1)));
      end
      4'd3, 4'd4: begin
        e = idle(ins[12] ? ST_ADD : ST_SUB);
        e.ra = ins[11:8]; e.rb = ins[7:4]; e.w_addr = ins[3:0]; e.w_en = 1'b1;
        e.alu_s = ins[12] ? 3'd1 : 3'd2;
        step(e, 1'($urandom_range(0, 1)));
      end
      4'd5: begin
        e = idle(ST_LDI); e.rf_s = 2'd2; e.rf_imm = ins[11:4]; e.w_addr = ins[3:0]; e.w_en = 1'b1;
        step(e, 1'($urandom_range(0, 1)));
      end
      4'd6: begin
        e = idle(ST_JPZ); e.ra = ins[11:8];
        if (rz) begin e.pc_ld = 1'b1; e.pc_offset = ins[7:0]; end
        step(e, 1'($urandom_range(0, 1)));
      end
      default: begin
        e = idle(ST_HALT); e.halted = 1'b1;
        n = $urandom_range(0, 3);
        repeat (n) step(e, 1'b0);
        step(e, 1'b1);
        resume = 1'b0;
      end
    endcase
  endtask

  task automatic reset_in_load(input int cyc);
    exp_t e;
    instr   = 16'h20A7;
    ra_zero = 1'b0;
    fetch_decode(instr);
    for (int k = 0; k < cyc - 1; k++) begin
      e = idle(ST_LOAD); e.d_addr = 8'h0A; e.rf_s = 2'd1; e.w_addr = 4'd7;
      e.w_en = (k == LAT - 1);
      step(e, 1'b0);
    end
    check_val("load_wen_pre_rst", rf_w_en, (cyc == LAT));
    #2;
    reset = 1'b0;
    ill_m = 1'b0;
    #1;
    e = idle(ST_INIT); e.pc_clr = 1'b1;
    compare(e);
    @(posedge clk); #1;
    compare(e);
    @(negedge clk);
    reset = 1'b1;
    step(e, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [15:0] ins;
    reset   = 1'b0;
    instr   = 16'h0000;
    ra_zero = 1'b0;
    resume  = 1'b0;
    ill_m   = 1'b0;
    e = idle(ST_INIT); e.pc_clr = 1'b1;
    #1;
    compare(e);
    @(posedge clk); #1;
    compare(e);
    @(negedge clk);
    reset = 1'b1;
    step(e, 1'b0);

    run_instr(16'h0000, 1'b0);
    run_instr(16'h20A7, 1'b0);
    run_instr(16'h5FF2, 1'b0);
    run_instr(16'h61FC, 1'b1);
    run_instr(16'h61FC, 1'b0);
    run_instr(16'h1F29, 1'b0);
    run_instr(16'h3A5C, 1'b1);
    run_instr(16'h4123, 1'b0);
    run_instr(16'h7000, 1'b0);
    run_instr(16'h9000, 1'b0);
    run_instr(16'h0000, 1'b0);

    reset_in_load(2);
    for (int i = 0; i < 80; i++) begin
      ins = 16'($urandom);
      ins[15:12] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(8, 15))
                                                : 4'($urandom_range(0, 7));
      run_instr(ins, 1'($urandom_range(0, 1)));
    end
    reset_in_load(3);
    run_instr(16'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit_v2.md
CONTROL_UNIT_V2 -- requirements
Module: control_unit_v2

Interface
REQ-001 Parameter D_ADDR_W, default 8: data-memory address width; STORE/LOAD use instr[D_ADDR_W-1:0] and instr[D_ADDR_W+3:4], both clipped to the 8 available bits.
REQ-002 Parameter RF_ADDR_W, default 4: register-file address width; legal range 1..4.
REQ-003 Parameter ALU_SEL_W, default 3: ALU select width.
REQ-004 Parameter MEM_LAT, default 2: data-memory read latency in cycles; legal range 1..7.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port instr, input, 16: IR contents; opcode in [15:12].
REQ-008 Port ra_zero, input, 1: datapath flag, 1 when the RF read port A value is zero.
REQ-009 Port resume, input, 1: single-cycle pulse that leaves HALT.
REQ-010 Port pc_clr / pc_up / pc_ld, output, 1 each: PC clear / increment / add offset.
REQ-011 Port pc_offset, output, 8: signed PC offset, equal to instr[7:0] when pc_ld=1, else 0.
REQ-012 Port ir_ld, output, 1: IR load.
REQ-013 Port d_addr, output, D_ADDR_W: data-memory address; d_wr, output, 1: data-memory write.
REQ-014 Port rf_s, output, 2: write-data select; 0=ALU, 1=memory, 2=immediate.
REQ-015 Port rf_imm, output, 8: immediate value, equal to instr[11:4] during LDI, else 0.
REQ-016 Port rf_w_addr, rf_ra_addr, rf_rb_addr, output, RF_ADDR_W each; rf_w_en, output, 1.
REQ-017 Port alu_s, output, ALU_SEL_W: 0=pass, 1=add, 2=sub.
REQ-018 Port state_out, output, 4: encoded current state; halted and illegal, output, 1 each.

Function
REQ-019 States: INIT, FETCH, DECODE, NOOP, STORE, LOAD, ADD, SUB, LDI, JPZ, HALT; encoding taken from the package enum.
REQ-020 Every output not explicitly asserted in a state SHALL be 0. Outputs are combinational from the current state and instr.
REQ-021 INIT: pc_clr=1; next state FETCH.
REQ-022 FETCH: pc_up=1 and ir_ld=1; next state DECODE.
REQ-023 DECODE opcode map: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 LDI, 6 JPZ, 7 HALT.
REQ-024 DECODE, opcodes 8-15: next state HALT; the sticky illegal flag is set on the same edge.
REQ-025 NOOP: one cycle; next state FETCH.
REQ-026 STORE: d_addr=instr[7:0], rf_ra_addr=instr[11:8], d_wr=1 for exactly one cycle; next state FETCH.
REQ-027 LOAD holds d_addr=instr[11:4], rf_s=1 and rf_w_addr=instr[3:0] for exactly MEM_LAT cycles, counted by an internal 3-bit counter.
REQ-028 LOAD: rf_w_en=1 only in the final (MEM_LAT-th) cycle; then next state FETCH.
REQ-029 LOAD counter: cleared on entry to LOAD and on reset.
REQ-030 ADD/SUB: rf_ra_addr=instr[11:8], rf_rb_addr=instr[7:4], rf_w_addr=instr[3:0], rf_w_en=1, rf_s=0; alu_s=1 (ADD) or 2 (SUB); one cycle; next state FETCH.
REQ-031 LDI: rf_s=2, rf_imm=instr[11:4], rf_w_addr=instr[3:0], rf_w_en=1; one cycle; next state FETCH.
REQ-032 JPZ: rf_ra_addr=instr[11:8]; if ra_zero=1, pc_ld=1 and pc_offset=instr[7:0]; offset is relative to the already-incremented PC; one cycle; next state FETCH either way.
REQ-033 HALT: halted=1, all other control outputs 0; state held until resume=1 is sampled, then next state FETCH.
REQ-034 A resume pulse seen in any state other than HALT SHALL be ignored.
REQ-035 illegal SHALL stay 1 through resume and clear only on reset.
REQ-036 Address fields wider than RF_ADDR_W SHALL be truncated to their LSBs.

Reset
REQ-037 While reset=0: state INIT, LOAD counter 0, illegal 0; outputs take their INIT values immediately (pc_clr=1, all others 0).
REQ-038 Reset asserted mid-operation (e.g. during LOAD) SHALL deassert rf_w_en/d_wr asynchronously; no write may complete.
REQ-039 First rising edge after reset release: INIT -> FETCH.

Structure
REQ-040 Shared package cu_pkg SHALL hold the opcode enum, the state enum (4-bit), rf_s select constants and alu_s constants.
REQ-041 The block is a single module with no sub-module; the latency counter is inline.

Verification
REQ-042 Reset release then instr=16'h0000 -> INIT, FETCH, DECODE, NOOP, FETCH; pc_clr=1 only in INIT.
REQ-043 MEM_LAT=3, instr=16'h20A7 -> LOAD for 3 cycles with d_addr=8'h0A, rf_w_addr=7; rf_w_en=1 in cycle 3 only.
REQ-044 instr=16'h5FF2 -> LDI with rf_s=2, rf_imm=8'hFF, rf_w_addr=2, rf_w_en=1 for one cycle.
REQ-045 instr=16'h61FC: ra_zero=1 -> pc_ld=1, pc_offset=8'hFC; ra_zero=0 -> pc_ld=0; next state FETCH in both cases.
REQ-046 instr=16'h9000 -> HALT with illegal=1 and halted=1; a resume pulse leads to FETCH with illegal still 1.
REQ-047 instr=16'h1F29 -> STORE with d_wr=1, d_addr=8'h29, rf_ra_addr=15.
REQ-048 reset=0 asserted in LOAD cycle 2 -> rf_w_en=0 immediately and state_out=INIT.
